// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared port ids, response tag and command types for the data-memory arbiter
package dmem_arb_pkg;
  localparam logic PORT_P = 1'b0;
  localparam logic PORT_A = 1'b1;
  localparam int CMD_ADDR_MAX = 32;
  localparam int CMD_DATA_MAX = 64;
  typedef struct packed {
    logic valid;
    logic port;
  } tag_t;
  typedef struct packed {
    logic [CMD_ADDR_MAX-1:0] addr;
    logic [CMD_DATA_MAX-1:0] data;
    logic                    wren;
  } cmd_t;
endpackage

// File: rtl/dmem_rsp_tracker.sv
// dmem_rsp_tracker: tag shift register following each issued command to its read-data slot
// ports: clock, reset (async active-low clear), tag_in (tag of the command issued this edge),
//        tag_out (tag whose memory data is on mem_q this cycle)
module dmem_rsp_tracker
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clock,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);
  tag_t [DEPTH-1:0] sr;
  always_ff @(posedge clock or negedge reset)
    if (!reset) sr <= '0;
    else sr <= {sr[DEPTH-2:0], tag_in};
  assign tag_out = sr[DEPTH-1];
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of a single-port synchronous data memory between ports P and A
// ports: clock, reset (async active-low); p_*/a_* requester command, grant and read-return;
//        mem_addr/mem_data/mem_wren registered memory command; mem_q memory read data
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              p_req,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_data,
  input  logic              p_wren,
  output logic              p_gnt,
  output logic              p_rvalid,
  output logic [DATA_W-1:0] p_q,
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              a_wren,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_q,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
);
  logic last, acc, win, unused_cmd;
  cmd_t sel;
  tag_t tag_out;
  // reset gates the grants because last already points at A while reset is held
  assign p_gnt = reset && p_req && (!a_req || last == PORT_A);
  assign a_gnt = reset && a_req && (!p_req || last == PORT_P);
  assign acc   = p_gnt || a_gnt;
  assign win   = a_gnt ? PORT_A : PORT_P;
  always_comb begin
    sel.addr = CMD_ADDR_MAX'(a_gnt ? a_addr : p_addr);
    sel.data = CMD_DATA_MAX'(a_gnt ? a_data : p_data);
    sel.wren = a_gnt ? a_wren : p_wren;
  end
  assign unused_cmd = ^{sel.addr, sel.data};
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      last     <= PORT_A;
      mem_addr <= '0;
      mem_data <= '0;
      mem_wren <= 1'b0;
    end else begin
      mem_wren <= acc && sel.wren;
      if (acc) begin
        last     <= win;
        mem_addr <= sel.addr[ADDR_W-1:0];
        mem_data <= sel.data[DATA_W-1:0];
      end
    end
  dmem_rsp_tracker #(.DEPTH(MEM_LAT + 1)) u_trk (
    .clock  (clock),
    .reset  (reset),
    .tag_in ('{valid: acc && !sel.wren, port: win}),
    .tag_out(tag_out)
  );
  assign p_rvalid = tag_out.valid && tag_out.port == PORT_P;
  assign a_rvalid = tag_out.valid && tag_out.port == PORT_A;
  assign p_q      = mem_q;
  assign a_q      = mem_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven arbitration vectors, read scoreboard and multi-cycle corner sequences
module tb_dmem_arbiter;
  localparam int MEM_LAT = 2;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        p_req = 1'b0, a_req = 1'b0, p_wren = 1'b0, a_wren = 1'b0;
  logic [11:0] p_addr = '0, a_addr = '0;
  logic [31:0] p_data = '0, a_data = '0;
  logic        p_gnt, a_gnt, p_rvalid, a_rvalid, mem_wren;
  logic [31:0] p_q, a_q, mem_data, mem_q;
  logic [11:0] mem_addr;
  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .MEM_LAT(MEM_LAT)) dut (
    .clock(clock), .reset(reset),
    .p_req(p_req), .p_addr(p_addr), .p_data(p_data), .p_wren(p_wren),
    .p_gnt(p_gnt), .p_rvalid(p_rvalid), .p_q(p_q),
    .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_wren(a_wren),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_q(a_q),
    .mem_addr(mem_addr), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
  );
  always #5 clock = ~clock;
  logic [31:0] mem [4096];
  logic [31:0] exp_mem [4096];
  logic [31:0] q_pipe [MEM_LAT];
  always @(posedge clock) begin
    q_pipe[0] <= mem[mem_addr];
    for (int i = 1; i < MEM_LAT; i++) q_pipe[i] <= q_pipe[i-1];
    if (mem_wren) mem[mem_addr] <= mem_data;
  end
  assign mem_q = q_pipe[MEM_LAT-1];
  int n_tests = 0, n_fail = 0, cyc = 0, wcnt = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (mem_wren) wcnt <= wcnt + 1;
  typedef struct {
    logic        port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  always @(negedge clock) begin
    if (p_rvalid || a_rvalid) begin
      n_tests++;
      if (p_rvalid && a_rvalid) begin
        n_fail++;
        $display("FAIL sb_both_rvalid: p_rvalid=1 a_rvalid=1 required at most one");
      end else if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: rvalid p=%0b a=%0b with no read outstanding", p_rvalid, a_rvalid);
      end else begin
        e = sbq.pop_front();
        if (a_rvalid != e.port || (a_rvalid ? a_q : p_q) != e.data || cyc != e.due) begin
          n_fail++;
          $display("FAIL sb_read: got port=%0b q=%h cyc=%0d required port=%0b q=%h cyc=%0d",
                   a_rvalid, a_rvalid ? a_q : p_q, cyc, e.port, e.data, e.due);
        end
      end
    end
    if (reset && (p_gnt || a_gnt)) begin
      if (p_gnt && a_gnt) begin
        n_tests++;
        n_fail++;
        $display("FAIL one_grant: p_gnt=1 a_gnt=1 required at most one");
      end
      if (p_gnt) begin
        if (p_wren) exp_mem[p_addr] = p_data;
        else sbq.push_back('{1'b0, exp_mem[p_addr], cyc + MEM_LAT + 1});
      end
      if (a_gnt) begin
        if (a_wren) exp_mem[a_addr] = a_data;
        else sbq.push_back('{1'b1, exp_mem[a_addr], cyc + MEM_LAT + 1});
      end
    end
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic pulse_reset();
    @(posedge clock);
    #1 reset = 1'b0;
    sbq.delete();
    step();
    step();
    reset = 1'b1;
  endtask
  typedef struct {
    logic        pr, ar;
    logic [11:0] pa, aa;
    logic        ep, ea;
  } vec_t;
  vec_t tbl[14];
  logic        got;
  logic [31:0] qv;
  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i]     = 32'hC0DE0000 + 32'(i) * 32'h00010001;
      exp_mem[i] = 32'hC0DE0000 + 32'(i) * 32'h00010001;
    end
    mem[12'h010]     = 32'hDEADBEEF;
    exp_mem[12'h010] = 32'hDEADBEEF;
    for (int i = 0; i < MEM_LAT; i++) q_pipe[i] = '0;
    tbl = '{
      '{1, 1, 12'h100, 12'h200, 1, 0}, '{1, 1, 12'h101, 12'h200, 0, 1},
      '{1, 1, 12'h101, 12'h201, 1, 0}, '{1, 1, 12'h102, 12'h201, 0, 1},
      '{1, 1, 12'h102, 12'h202, 1, 0}, '{1, 1, 12'h103, 12'h202, 0, 1},
      '{0, 0, 12'h000, 12'h000, 0, 0}, '{1, 0, 12'h104, 12'h000, 1, 0},
      '{1, 1, 12'h105, 12'h203, 0, 1}, '{1, 1, 12'h105, 12'h204, 1, 0},
      '{0, 1, 12'h000, 12'h204, 0, 1}, '{0, 1, 12'h000, 12'h205, 0, 1},
      '{1, 1, 12'h106, 12'h206, 1, 0}, '{0, 0, 12'h000, 12'h000, 0, 0}
    };
    p_req = 1'b1;
    a_req = 1'b1;
    @(negedge clock);
    chk("rst_p_gnt", p_gnt, 0);
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_mem_wren", mem_wren, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_data", mem_data, 0);
    chk("rst_rvalid", {p_rvalid, a_rvalid}, 0);
    p_req = 1'b0;
    a_req = 1'b0;
    step();
    reset = 1'b1;
    step();
    p_req  = 1'b1;
    p_addr = 12'h010;
    @(negedge clock);
    chk("first_p_gnt", {p_gnt, a_gnt}, 2'b10);
    step();
    p_req = 1'b0;
    for (int k = 1; k <= MEM_LAT + 1; k++) begin
      @(negedge clock);
      chk("first_p_rvalid", p_rvalid, k == MEM_LAT + 1);
      chk("first_a_rvalid", a_rvalid, 0);
      if (k == MEM_LAT + 1) chk("first_p_q", p_q, 32'hDEADBEEF);
    end
    pulse_reset();
    foreach (tbl[i]) begin
      p_req  = tbl[i].pr;
      a_req  = tbl[i].ar;
      p_addr = tbl[i].pa;
      a_addr = tbl[i].aa;
      @(negedge clock);
      chk($sformatf("tbl%0d_gnt", i), {p_gnt, a_gnt}, {tbl[i].ep, tbl[i].ea});
      step();
    end
    p_req = 1'b0;
    a_req = 1'b0;
    repeat (MEM_LAT + 3) step();
    wcnt   = 0;
    a_req  = 1'b1;
    a_wren = 1'b1;
    a_addr = 12'h0FF;
    a_data = 32'h12345678;
    @(negedge clock);
    chk("wr_a_gnt", a_gnt, 1);
    step();
    a_req  = 1'b0;
    a_wren = 1'b0;
    p_req  = 1'b1;
    p_addr = 12'h0FF;
    @(negedge clock);
    chk("rd_p_gnt", p_gnt, 1);
    chk("wr_mem_cmd", {mem_wren, mem_addr, mem_data}, {1'b1, 12'h0FF, 32'h12345678});
    step();
    p_req = 1'b0;
    got   = 1'b0;
    qv    = '0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clock);
      chk("raw_no_a_rvalid", a_rvalid, 0);
      if (p_rvalid) begin
        got = 1'b1;
        qv  = p_q;
      end
    end
    chk("raw_rvalid_seen", got, 1);
    chk("raw_p_q", qv, 32'h12345678);
    repeat (3) step();
    chk("wr_mem_wren_cycles", wcnt, 1);
    for (int i = 0; i < 4; i++) begin
      a_req  = 1'b1;
      a_addr = 12'h030 + 12'(i);
      @(negedge clock);
      chk($sformatf("aonly%0d_gnt", i), {p_gnt, a_gnt}, 2'b01);
      if (i > 0) chk($sformatf("aonly%0d_mem_addr", i), mem_addr, 12'h030 + 12'(i - 1));
      step();
    end
    a_req = 1'b0;
    @(negedge clock);
    chk("aonly_last_mem_addr", mem_addr, 12'h033);
    repeat (MEM_LAT + 3) step();
    p_req  = 1'b1;
    p_addr = 12'h040;
    step();
    p_req  = 1'b0;
    a_req  = 1'b1;
    a_addr = 12'h041;
    step();
    a_req = 1'b0;
    #2 reset = 1'b0;
    sbq.delete();
    @(negedge clock);
    chk("inflight_rst_mem_wren", mem_wren, 0);
    step();
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      chk("inflight_dropped", {p_rvalid, a_rvalid}, 0);
    end
    step();
    p_req  = 1'b1;
    a_req  = 1'b1;
    p_addr = 12'h050;
    a_addr = 12'h051;
    @(negedge clock);
    chk("post_rst_tie", {p_gnt, a_gnt}, 2'b10);
    step();
    p_req = 1'b0;
    a_req = 1'b0;
    repeat (MEM_LAT + 4) step();
    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
